// File: rtl/spi_pwm_cmd_rx.sv
// SPI command receiver: oversampled sclk/mosi, 16-bit frames, pset strobe.
// Define SPI_PWM_CMD_PARITY_EN to reject frames with odd population count.
module spi_pwm_cmd_rx #(
    parameter int SYNC_STAGES  = 2,
    parameter int IDLE_TIMEOUT = 64,
    parameter int NUM_CH       = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sclk,
    input  logic       mosi,
    output logic       pset,
    output logic [2:0] addr,
    output logic [7:0] level,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SHIFT  = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    localparam logic [7:0] TMO   = 8'(IDLE_TIMEOUT);
    localparam logic [3:0] NCH   = 4'(NUM_CH);
    localparam logic [4:0] LASTB = 5'd15;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_s;
    logic                   sclk_prev;
    logic                   rise_q;
    logic                   bit_q;

    logic [1:0]  state;
    logic [4:0]  bit_cnt;
    logic [7:0]  idle_cnt;
    logic [7:0]  idle_nxt;
    logic [14:0] shreg;
    logic [15:0] frame_nxt;
    logic [4:0]  frame_unused;
    logic        addr_ok;
    logic        par_ok;
    logic        accept;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];

    // Edge and data are registered together so both paths stay aligned.
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            sclk_prev <= 1'b0;
            rise_q    <= 1'b0;
            bit_q     <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_prev <= sclk_s;
            rise_q    <= sclk_s & ~sclk_prev;
            bit_q     <= mosi_sync[SYNC_STAGES-1];
        end
    end

    assign frame_nxt    = {shreg, bit_q};
    assign frame_unused = frame_nxt[15:11];
    assign busy         = (state == S_SHIFT);

    always_comb begin
        idle_nxt = idle_cnt + 8'd1;
        if (idle_cnt == TMO) begin
            idle_nxt = idle_cnt;
        end
    end

    always_comb begin
        addr_ok = ({1'b0, frame_nxt[10:8]} < NCH);
`ifdef SPI_PWM_CMD_PARITY_EN
        par_ok  = ~(^frame_nxt);
`else
        par_ok  = 1'b1;
`endif
        accept  = addr_ok & par_ok;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            bit_cnt   <= 5'd0;
            idle_cnt  <= 8'd0;
            shreg     <= 15'd0;
            pset      <= 1'b0;
            addr      <= 3'd0;
            level     <= 8'd0;
            frame_err <= 1'b0;
        end else begin
            pset      <= 1'b0;
            frame_err <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    idle_cnt <= 8'd0;
                    if (rise_q) begin
                        shreg   <= frame_nxt[14:0];
                        bit_cnt <= 5'd1;
                        state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    // A same-cycle edge beats the timeout.
                    if (rise_q) begin
                        shreg    <= frame_nxt[14:0];
                        bit_cnt  <= bit_cnt + 5'd1;
                        idle_cnt <= 8'd0;
                        if (bit_cnt == LASTB) begin
                            state <= S_COMMIT;
                            if (accept) begin
                                pset  <= 1'b1;
                                addr  <= frame_nxt[10:8];
                                level <= frame_nxt[7:0];
                            end else begin
                                frame_err <= 1'b1;
                            end
                        end
                    end else if (idle_nxt == TMO) begin
                        frame_err <= 1'b1;
                        state     <= S_IDLE;
                        bit_cnt   <= 5'd0;
                        idle_cnt  <= 8'd0;
                    end else begin
                        idle_cnt <= idle_nxt;
                    end
                end
                S_COMMIT: begin
                    state    <= S_IDLE;
                    bit_cnt  <= 5'd0;
                    idle_cnt <= 8'd0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/spi_pwm_cmd_rx.md
Name: spi_pwm_cmd_rx

Overview:
- Command front-end for the 7-channel PWM driver.
- Oversamples the external SPI pins (sclk, mosi) in the clk domain and assembles 16-bit frames.
- Decodes each frame into a channel address and an 8-bit level, then issues a single-cycle write strobe (pset/addr/level) to the PWM level registers downstream.
- No chip-select pin is available, so frame alignment is recovered by an idle timeout on sclk.

Parameters:
- SYNC_STAGES, 2: flip-flop stages on the sclk and mosi synchronisers (min 2).
- IDLE_TIMEOUT, 64: clk cycles without a synchronised sclk rising edge before a partial frame is discarded (min 4, max 255).
- NUM_CH, 7: number of valid channel addresses; addresses >= NUM_CH are rejected.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- sclk  input  1  SPI clock, asynchronous to clk, idle low, mode 0
- mosi  input  1  SPI data, MSB first, sampled on sclk rising edge
- pset  output  1  one-cycle write strobe to the PWM level registers
- addr  output  3  channel address; valid when pset=1, holds the last committed value otherwise
- level  output  8  PWM level; valid when pset=1, holds the last committed value otherwise
- frame_err  output  1  one-cycle pulse on a rejected or aborted frame
- busy  output  1  high while a frame is partially received

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- Reset values: pset=0, addr=0, level=0, frame_err=0, busy=0, state=IDLE, bit counter=0, idle counter=0, shift register=0. Synchroniser flops also reset to 0.
- Synchronisation and edge detect:
  - sclk and mosi each pass through SYNC_STAGES flops.
  - A rising edge is detected when the synchronised sclk is 1 and its previous value was 0.
  - mosi is sampled from its synchronised copy in the same cycle the edge is detected, so both paths have equal latency.
  - Requirement on the host: sclk high and low phases each >= SYNC_STAGES+1 clk cycles.
- Frame format, 16 bits MSB first:
  - [15] even parity over [14:0]
  - [14:11] reserved, ignored
  - [10:8] addr
  - [7:0] level
- State machine IDLE -> SHIFT -> COMMIT -> IDLE:
  - IDLE: the first rising edge shifts in bit 15, sets bit counter to 1, goes to SHIFT, busy=1.
  - SHIFT: each rising edge shifts left and increments the counter. When the 16th bit is captured, go to COMMIT.
  - SHIFT: the idle counter clears on every rising edge and otherwise increments. If it reaches IDLE_TIMEOUT, discard the frame, pulse frame_err for one cycle, go to IDLE, busy=0.
  - SHIFT: if a rising edge and the timeout occur in the same cycle, the edge wins; the counter clears and no abort happens.
  - COMMIT (exactly one cycle):
    - If addr < NUM_CH: pset=1, and addr/level are loaded from the frame in that same cycle.
    - Otherwise: frame_err=1, and addr/level are unchanged.
    - Next state is IDLE, busy=0.
    - A rising edge arriving during COMMIT cannot occur given the phase requirement; if one does, it is ignored.
- Latency: pset is asserted exactly 1 clk cycle after the cycle in which the 16th edge is detected. That is SYNC_STAGES+2 cycles after the pin-level 16th rising edge.
- Back-to-back frames need no gap; the next edge in IDLE starts a new frame.
- Reset mid-frame: the partial frame is discarded; no pset and no frame_err pulse.
- The bit counter is 5 bits wide and never wraps past 16. The idle counter is 8 bits wide and saturates at IDLE_TIMEOUT.

Optional Feature:
- Macro: SPI_PWM_CMD_PARITY_EN.
- Defined: in COMMIT, a frame whose 16 bits have odd population count is rejected. The block pulses frame_err, does not assert pset, and leaves addr/level unchanged. The parity check takes priority over the address check (only one frame_err pulse).
- Not defined: bit 15 is ignored, and acceptance depends only on addr < NUM_CH.

Test Plan:
- Send frame 0x8380 (addr 3, level 0x80, parity ok) -> one pset pulse with addr=3, level=0x80, SYNC_STAGES+2 cycles after the 16th edge. frame_err=0; busy falls with commit.
- Send 0x00FF then immediately 0x8601 -> two pset pulses: (0,0xFF), then (6,0x01). Outputs hold 6/0x01 afterwards.
- Send 0x0710 (addr 7) -> frame_err pulse, no pset, addr/level keep their previous values.
- Send 8 bits, then hold sclk low for IDLE_TIMEOUT cycles -> frame_err pulse, busy=0. A following 0x8380 is then received correctly.
- Assert reset after 10 bits of a frame -> no pset, no frame_err, all outputs 0. A subsequent 0x00FF produces pset with addr=0, level=0xFF.
- With SPI_PWM_CMD_PARITY_EN, send 0x0380 (bad parity) -> frame_err, no pset. Without the macro, the same frame gives pset with addr=3, level=0x80.
